regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32x32 register file. Two producers compete for the file's single write port: req0 (ALU result) and req1 (load/multi-cycle result). The block arbitrates them round-robin and drives a registered write stage into the file's WE/Rw/busW inputs. It also keeps a pending-write scoreboard, so the issue stage can stall on RAW hazards.

---
 rtl/regfile_wb_scheduler.sv | 70 +++++++
 tb/tb_regfile_wb_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin write-port arbiter with a registered write stage and a RAW scoreboard.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rw,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rw,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_busw,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] chk_ra,
  input  logic [ADDR_W-1:0] chk_rb,
  output logic              ra_busy,
  output logic              rb_busy
);
  localparam int NREG = 1 << ADDR_W;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0]   pend_q, pend_d, set_v, clr_v;
  logic              acc;
  logic [ADDR_W-1:0] acc_rw;
  logic [DATA_W-1:0] acc_data;
  // last_q=1 means req1 won last, so req0 wins a tie
  assign req0_ready = req0_valid && (!req1_valid || last_q);
  assign req1_ready = req1_valid && (!req0_valid || !last_q);
  assign acc        = req0_ready || req1_ready;
  assign acc_rw     = req0_ready ? req0_rw : req1_rw;
  assign acc_data   = req0_ready ? req0_data : req1_data;
  always_comb begin
    last_d = acc ? req1_ready : last_q;
    we_d   = acc && acc_rw != '0;
    rw_d   = we_d ? acc_rw : rw_q;
    data_d = we_d ? acc_data : data_q;
    set_v  = (issue_valid && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
    clr_v  = we_d ? NREG'(1) << acc_rw : '0;
    pend_d = (pend_q & ~clr_v) | set_v;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_q <= 1'b1;
      we_q   <= 1'b0;
      rw_q   <= '0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      rw_q   <= rw_d;
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end
  assign rf_we   = we_q;
  assign rf_rw   = rw_q;
  assign rf_busw = data_q;
  assign ra_busy = pend_q[chk_ra] && chk_ra != '0;
  assign rb_busy = pend_q[chk_rb] && chk_rb != '0;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed test-plan scenarios plus random traffic against a behavioural model.
module tb_regfile_wb_scheduler;
  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, issue_valid = 0;
  logic        req0_ready, req1_ready, rf_we, ra_busy, rb_busy;
  logic [4:0]  req0_rw = 0, req1_rw = 0, issue_rd = 0, chk_ra = 0, chk_rb = 0, rf_rw;
  logic [31:0] req0_data = 0, req1_data = 0, rf_busw;
  int checks = 0, failures = 0;

  regfile_wb_scheduler dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw), .req1_data(req1_data),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_busw(rf_busw),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .ra_busy(ra_busy), .rb_busy(rb_busy)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endfunction

  // model: who won last, which registers await a write, and the write due on the file port
  int          m_last;
  bit          m_pend[32];
  bit          m_we, m_acc0, m_acc1;
  logic [4:0]  m_rw;
  logic [31:0] m_data;

  always @(negedge Clk) begin
    int win;
    logic [4:0] wrw;
    if (!Rst_n) begin
      m_last = 1; m_we = 0; m_rw = 0; m_data = 0; m_acc0 = 0; m_acc1 = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      chk("rst_we", rf_we, 0);
      chk("rst_rw", rf_rw, 0);
      chk("rst_busw", rf_busw, 0);
    end else begin
      if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
      else win = -1;
      chk("m_ready0", req0_ready, win == 0);
      chk("m_ready1", req1_ready, win == 1);
      chk("m_ra_busy", ra_busy, chk_ra != 0 && m_pend[chk_ra]);
      chk("m_rb_busy", rb_busy, chk_rb != 0 && m_pend[chk_rb]);
      chk("m_we", rf_we, m_we);
      if (m_we) begin
        chk("m_rw", rf_rw, m_rw);
        chk("m_busw", rf_busw, m_data);
      end
      m_acc0 = win == 0;
      m_acc1 = win == 1;
      m_we = 0;
      if (win >= 0) begin
        m_last = win;
        wrw = win == 0 ? req0_rw : req1_rw;
        if (wrw != 0) begin
          m_we = 1; m_rw = wrw; m_data = win == 0 ? req0_data : req1_data;
          m_pend[wrw] = 0;
        end
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    @(posedge Clk); #2 Rst_n = 0;
    @(negedge Clk);
    @(posedge Clk); #2 Rst_n = 1;
  endtask

  initial begin
    int exp_rw[4] = '{1, 9, 2, 10};
    do_reset();
    // test 1: single write latency
    step(); req0_valid = 1; req0_rw = 5; req0_data = 32'hDEADBEEF;
    #1 chk("t1_ready0", req0_ready, 1);
    step(); req0_valid = 0;
    #1 chk("t1_we", rf_we, 1); chk("t1_rw", rf_rw, 5); chk("t1_busw", rf_busw, 32'hDEADBEEF);
    step(); #1 chk("t1_we_off", rf_we, 0);
    // test 2: alternating grants after reset
    do_reset();
    #1 req0_valid = 1; req1_valid = 1; req0_rw = 1; req1_rw = 9;
    req0_data = 32'h100; req1_data = 32'h900;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_grant0", req0_ready, k % 2 == 0);
      chk("t2_grant1", req1_ready, k % 2 == 1);
      step();
      chk("t2_rf_rw", rf_rw, exp_rw[k]);
      if (k % 2 == 0) req0_rw++; else req1_rw++;
    end
    req0_valid = 0;
    #1 chk("t2_solo_a", req1_ready, 1);
    step(); req1_rw++;
    #1 chk("t2_solo_b", req1_ready, 1);
    step(); req1_valid = 0;
    // test 3: register 0 write
    step(); req1_valid = 1; req1_rw = 0; req1_data = 32'h1234;
    #1 chk("t3_ready1", req1_ready, 1);
    step(); req1_valid = 0;
    #1 chk("t3_we", rf_we, 0);
    // test 4: scoreboard set/clear timing
    step(); issue_valid = 1; issue_rd = 7; chk_ra = 7; chk_rb = 0;
    step(); issue_valid = 0; req0_valid = 1; req0_rw = 7; req0_data = 32'h77;
    #1 chk("t4_busy_N", ra_busy, 1); chk("t4_ready0", req0_ready, 1); chk("t4_rb0", rb_busy, 0);
    step(); req0_valid = 0;
    #1 chk("t4_busy_N1", ra_busy, 0); chk("t4_we", rf_we, 1);
    // test 5: set wins over clear
    step(); issue_valid = 1; issue_rd = 3; chk_ra = 3;
    step(); req0_valid = 1; req0_rw = 3; req0_data = 32'h33;
    #1 chk("t5_busy_pre", ra_busy, 1);
    step(); issue_valid = 0; req0_valid = 0;
    #1 chk("t5_busy_kept", ra_busy, 1);
    step(); #1 chk("t5_busy_still", ra_busy, 1);
    req0_valid = 1;
    step(); req0_valid = 0;
    #1 chk("t5_busy_clr", ra_busy, 0);
    // test 6: async reset with a write in the output stage
    step(); issue_valid = 1; issue_rd = 6; chk_ra = 6;
    step(); issue_valid = 0; req0_valid = 1; req0_rw = 6; req0_data = 32'h66;
    step(); req0_valid = 0;
    #1 chk("t6_we_before", rf_we, 1);
    issue_valid = 1; issue_rd = 6;
    step(); issue_valid = 0;
    #1 chk("t6_busy_before", ra_busy, 1);
    Rst_n = 0;
    #1 chk("t6_we_async", rf_we, 0); chk("t6_busy_async", ra_busy, 0);
    @(negedge Clk);
    @(posedge Clk); #2 Rst_n = 1;
    #1 req0_valid = 1; req1_valid = 1; req0_rw = 1; req1_rw = 2;
    #1 chk("t6_first_grant0", req0_ready, 1); chk("t6_first_grant1", req1_ready, 0);
    step(); req0_valid = 0; req1_valid = 0;
    // random traffic; requesters hold until the model says they were accepted
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!req0_valid || m_acc0) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_rw = 5'($urandom_range(0, 7)); req0_data = $urandom;
      end
      if (!req1_valid || m_acc1) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_rw = 5'($urandom_range(0, 7)); req1_data = $urandom;
      end
      issue_valid = $urandom_range(0, 3) == 0;
      issue_rd = 5'($urandom_range(0, 7));
      chk_ra = 5'($urandom_range(0, 7));
      chk_rb = 5'($urandom_range(0, 7));
      if (c == 1500) begin
        #2 Rst_n = 0;
        @(negedge Clk);
        @(posedge Clk); #2 Rst_n = 1;
        req0_valid = 0; req1_valid = 0;
      end
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
